// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store unit between the core and a single-outstanding data bus.
// It decodes and validates the core access, drives a request/grant/rvalid bus
// transaction, extends load data and aborts accesses that exceed TIMEOUT cycles.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a core request; illegal requests get err here
// S_REQ  | bus_req high, waiting for bus_gnt
// S_WAIT | read granted, waiting for bus_rvalid
// S_DONE | one-cycle completion; err here marks a timeout abort
module data_mem_ctrl #(
   parameter int unsigned TIMEOUT = 255   // legal range 1..255 cycles in REQ+WAIT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   input  logic [2:0]  funct3,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Last counter value still inside the cycle budget.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;
   logic        to_q;
   logic        timeout_hit;
   logic        f3_ok, aligned, req_ok, req_bad;
   logic [3:0]  be_d;
   logic [31:0] wdata_d;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;

   // Classify the core request: size/sign legal for its direction and naturally aligned.
   always_comb begin
      case (funct3)
         3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
         3'b100, 3'b101:         f3_ok = ~mem_write;
         default:                f3_ok = 1'b0;
      endcase
      case (funct3[1:0])
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b1;
      endcase
      req_ok  = (mem_read ^ mem_write) & f3_ok & aligned;
      req_bad = (mem_read | mem_write) & ~req_ok;
   end

   // Byte enables and lane-replicated store data for the requested size.
   always_comb begin
      case (funct3[1:0])
         2'b00: begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
         end
         2'b01: begin
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata[15:0]}};
         end
         default: begin
            be_d    = 4'b1111;
            wdata_d = wdata;
         end
      endcase
   end

   // Select and extend the addressed byte/half of the returned bus word.
   always_comb begin
      case (off_q)
         2'd0:    byte_sel = bus_rdata[7:0];
         2'd1:    byte_sel = bus_rdata[15:8];
         2'd2:    byte_sel = bus_rdata[23:16];
         default: byte_sel = bus_rdata[31:24];
      endcase
      half_sel = off_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
      case (f3_q)
         3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  load_ext = {24'd0, byte_sel};
         3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
         3'b101:  load_ext = {16'd0, half_sel};
         default: load_ext = bus_rdata;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Next state; a write grant wins over the budget, a read grant on the last cycle does not.
   always_comb begin
      state_d     = state_q;
      timeout_hit = 1'b0;
      case (state_q)
         S_IDLE: if (req_ok) state_d = S_REQ;
         S_REQ: begin
            if (bus_gnt && bus_we) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_DONE;
               timeout_hit = 1'b1;
            end else if (bus_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (bus_rvalid) begin
               state_d = S_DONE;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = S_DONE;
               timeout_hit = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Core/bus handshake outputs, forced low while reset is held.
   always_comb begin
      stall   = ~rst & (((state_q == S_IDLE) & req_ok) | (state_q == S_REQ) | (state_q == S_WAIT));
      bus_req = (state_q == S_REQ);
      err     = ~rst & (((state_q == S_IDLE) & req_bad) | ((state_q == S_DONE) & to_q));
   end

   // Capture the bus command when an access is accepted; held stable until the next one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_be    <= '0;
         bus_we    <= 1'b0;
         f3_q      <= '0;
         off_q     <= '0;
      end else if ((state_q == S_IDLE) && req_ok) begin
         bus_addr  <= {addr[31:2], 2'b00};
         bus_wdata <= wdata_d;
         bus_be    <= be_d;
         bus_we    <= mem_write;
         f3_q      <= funct3;
         off_q     <= addr[1:0];
      end
   end

   // Cycle budget counter, timeout flag and load result register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
         rdata <= '0;
      end else begin
         to_q <= timeout_hit;
         if ((state_q == S_IDLE) && req_ok)
            cnt_q <= '0;
         else if ((state_q == S_REQ) || (state_q == S_WAIT))
            cnt_q <= cnt_q + 8'd1;
         if ((state_q == S_WAIT) && bus_rvalid)
            rdata <= load_ext;
         else if (timeout_hit && !bus_we)
            rdata <= '0;
      end
   end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255, meaning the maximum number of cycles spent in REQ plus WAIT before an access is aborted; the legal range SHALL be 1..255.
REQ-002 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 mem_read  input  1  core load request, held for the whole instruction.
REQ-005 mem_write  input  1  core store request, held for the whole instruction.
REQ-006 addr  input  32  byte address, taken from the core ALU result.
REQ-007 wdata  input  32  core store data, taken from rs2.
REQ-008 funct3  input  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-009 rdata  output  32  extended load result for core write-back.
REQ-010 stall  output  1  core SHALL hold PC and inputs while high.
REQ-011 err  output  1  one-cycle pulse for a misaligned, illegal or timed-out access.
REQ-012 bus_req  output  1  bus request.
REQ-013 bus_we  output  1  bus write flag (1 = write).
REQ-014 bus_addr  output  32  word-aligned address, bits [1:0] = 00.
REQ-015 bus_wdata  output  32  lane-replicated store data.
REQ-016 bus_be  output  4  byte enables.
REQ-017 bus_gnt  input  1  bus accepted the request this cycle.
REQ-018 bus_rvalid  input  1  read data valid this cycle.
REQ-019 bus_rdata  input  32  bus read data.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT and DONE.
REQ-021 In IDLE with exactly one of mem_read/mem_write high, legal funct3 and aligned addr, the block SHALL register addr, bus_be, bus_wdata, bus_we and funct3, then go to REQ.
REQ-022 Alignment rules: H/HU SHALL need addr[0]=0; W SHALL need addr[1:0]=00.
REQ-023 In IDLE, a misaligned access, an illegal funct3, or mem_read and mem_write both high SHALL:
- pulse err for 1 cycle;
- issue no bus access and suppress the store;
- leave rdata unchanged;
- hold stall low;
- stay in IDLE.
REQ-024 Legal store funct3 values SHALL be 000, 001 and 010 only; legal load values SHALL be 000, 001, 010, 100 and 101.
REQ-025 stall SHALL be combinational: (IDLE and a legal request) or REQ or WAIT; it SHALL be low in DONE.
REQ-026 bus_req SHALL be high only in REQ, with bus_addr, bus_we, bus_be and bus_wdata stable until bus_gnt.
REQ-027 In REQ with bus_gnt, the FSM SHALL go to DONE for a write and to WAIT for a read.
REQ-028 In WAIT with bus_rvalid, the block SHALL register the extended load data into rdata and go to DONE.
REQ-029 bus_rvalid in the same cycle as bus_gnt SHALL be ignored; the block SHALL accept read data in WAIT only.
REQ-030 Load extraction:
- B/BU SHALL select byte addr[1:0];
- H/HU SHALL select half addr[1];
- B/H SHALL sign-extend and BU/HU SHALL zero-extend to 32 bits.
REQ-031 Store lanes and byte enables:
- SB SHALL replicate wdata[7:0] into all 4 lanes, with bus_be = 0001 << addr[1:0];
- SH SHALL replicate wdata[15:0] into both halves, with bus_be = 0011 or 1100 by addr[1];
- SW SHALL use bus_be = 1111.
REQ-032 DONE SHALL last exactly 1 cycle and then go to IDLE; the still-asserted request from the completing instruction SHALL NOT restart an access.
REQ-033 An 8-bit timeout counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-034 When the counter reaches TIMEOUT, the FSM SHALL go to DONE with err pulsed, rdata = 0 for a load, and bus_req dropped.
REQ-035 rdata SHALL hold its value until the next completed load.

Reset
REQ-036 While rst is high, the FSM SHALL go to IDLE and the counter to 0 immediately, without waiting for clk.
REQ-037 During reset, rdata, bus_addr, bus_wdata, bus_be, bus_we, bus_req, stall and err SHALL all be 0.
REQ-038 A reset asserted in REQ or WAIT SHALL drop bus_req asynchronously, and a later bus_rvalid SHALL be ignored.

Verification
REQ-039 The bench SHALL cover the following scenarios:
- LW addr=0x100, gnt after 2 cycles, rvalid=0xDEADBEEF 1 cycle later -> stall high 4 cycles; rdata=0xDEADBEEF in DONE; bus_addr=0x100, be=1111.
- LB addr=0x103, bus_rdata=0x80000000 -> rdata=0xFFFFFF80; LBU same -> rdata=0x00000080.
- SH addr=0x102, wdata=0x1234ABCD, gnt immediate -> bus_wdata=0xABCDABCD, be=1100, bus_we=1; DONE follows the gnt cycle.
- LW addr=0x101 -> err pulses 1 cycle, bus_req never rises, stall low, rdata unchanged.
- TIMEOUT=4, LW with gnt never asserted -> err pulse after 4 REQ cycles; rdata=0; FSM returns to IDLE.
- rst pulse mid-WAIT, then bus_rvalid -> bus_req=0 and stall=0 at once; rdata stays 0.
